// File: rtl/shift_sequencer16.sv
// Multi-cycle shift/rotate controller for an external combinational 16-bit
// single-step shifter: one bit per clock, HOut fed back into the working register.
module shift_sequencer16 #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [3:0]       Amount,
  input  logic [WIDTH-1:0] Operand,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic [1:0]       ShSelect,
  output logic [WIDTH-1:0] ShB,
  output logic             ShInL,
  output logic             ShInR,
  input  logic [WIDTH-1:0] ShHOut
);

  // state | meaning
  // IDLE  | waiting for Start; shifter passes B
  // SHIFT | one single-bit step per clock, Cnt counts down to 1
  // DONE  | one-cycle Done pulse, Result/Carry valid
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  state_t           state, state_next;
  logic [WIDTH-1:0] r;
  logic [3:0]       cnt;
  logic [2:0]       op_reg;
  logic             go_shift;

  // Reserved ops and zero amounts skip SHIFT and return the operand unchanged.
  assign go_shift = (Amount != 4'd0) && (Op <= OP_ROR);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ShSelect   = 2'b00;
    ShInL      = 1'b0;
    ShInR      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_next = go_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == 4'd1) state_next = DONE;
        case (op_reg)
          OP_LSL: ShSelect = 2'b01;
          OP_LSR: ShSelect = 2'b10;
          OP_ASR: begin
            ShSelect = 2'b10;
            ShInL    = r[WIDTH-1];
          end
          OP_ROL: begin
            ShSelect = 2'b01;
            ShInR    = r[WIDTH-1];
          end
          OP_ROR: begin
            ShSelect = 2'b10;
            ShInL    = r[0];
          end
          default: ShSelect = 2'b00;
        endcase
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);
  assign ShB  = r;

  // Result is loaded with the value R takes on entry to DONE, so it is
  // already valid in the Done cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r      <= '0;
      cnt    <= 4'd0;
      op_reg <= 3'd0;
      Carry  <= 1'b0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            r      <= Operand;
            cnt    <= Amount;
            op_reg <= Op;
            Carry  <= 1'b0;
            if (!go_shift) Result <= Operand;
          end
        end
        SHIFT: begin
          r   <= ShHOut;
          cnt <= cnt - 4'd1;
          if ((op_reg == OP_LSL) || (op_reg == OP_ROL)) Carry <= r[WIDTH-1];
          else                                          Carry <= r[0];
          if (cnt == 4'd1) Result <= ShHOut;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer16.sv
// Directed bench for shift_sequencer16 with a behavioural model of the
// external single-step shifter closing the R -> ShB -> HOut loop.
module tb_shift_sequencer16;

  logic        CLK, nRST, Start;
  logic [2:0]  Op;
  logic [3:0]  Amount;
  logic [15:0] Operand;
  logic        Busy, Done, Carry, ShInL, ShInR;
  logic [15:0] Result, ShB, ShHOut;
  logic [1:0]  ShSelect;

  int total = 0;
  int bad   = 0;

  shift_sequencer16 #(.WIDTH(16)) dut (
    .CLK(CLK), .nRST(nRST), .Start(Start), .Op(Op), .Amount(Amount),
    .Operand(Operand), .Busy(Busy), .Done(Done), .Result(Result),
    .Carry(Carry), .ShSelect(ShSelect), .ShB(ShB), .ShInL(ShInL),
    .ShInR(ShInR), .ShHOut(ShHOut)
  );

  always_comb begin
    case (ShSelect)
      2'b01:   ShHOut = {ShB[14:0], ShInR};
      2'b10:   ShHOut = {ShInL, ShB[15:1]};
      default: ShHOut = ShB;
    endcase
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the command is accepted at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [15:0] val);
    Op = op; Amount = amt; Operand = val; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
  endtask

  // Samples each cycle after acceptance at the negedge until Done appears.
  // With hammer set, Start is held high with changing operands while busy.
  task automatic wait_done(input string tag, input logic [15:0] exp_res, input logic exp_c,
                           input int exp_lat, input logic exp_sel, input logic hammer);
    int lat = 0;
    int busy_cnt = 0;
    logic sel_seen = 1'b0;
    logic got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge CLK);
      lat = k;
      if (Busy) busy_cnt++;
      if (ShSelect != 2'b00) sel_seen = 1'b1;
      if (Done) got = 1'b1;
      if (hammer) begin
        Start = 1'b1;
        Operand = Operand + 16'h1111;
        Op = 3'd1;
        Amount = 4'd7;
      end
    end
    check({tag, " done_seen"}, got, 1'b1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat);
    check({tag, " result"}, Result, exp_res);
    check({tag, " carry"}, Carry, exp_c);
    check({tag, " shselect_used"}, sel_seen, exp_sel);
    @(posedge CLK);
    @(negedge CLK);
    check({tag, " done_width"}, Done, 1'b0);
    check({tag, " idle_after"}, Busy, 1'b0);
    check({tag, " result_hold"}, Result, exp_res);
  endtask

  initial begin
    nRST = 1'b0; Start = 1'b0; Op = 3'd0; Amount = 4'd0; Operand = 16'h0;
    #1;
    check("rst busy", Busy, 1'b0);
    check("rst done", Done, 1'b0);
    check("rst result", Result, 16'h0);
    check("rst shb", ShB, 16'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    issue(3'd0, 4'd1, 16'h8001);
    wait_done("lsl1", 16'h0002, 1'b1, 2, 1'b1, 1'b0);

    issue(3'd2, 4'd15, 16'h8000);
    wait_done("asr15", 16'hFFFF, 1'b0, 16, 1'b1, 1'b0);

    issue(3'd1, 4'd8, 16'hFFFF);
    wait_done("lsr8", 16'h00FF, 1'b1, 9, 1'b1, 1'b0);

    issue(3'd4, 4'd4, 16'h000F);
    wait_done("ror4", 16'hF000, 1'b1, 5, 1'b1, 1'b0);

    issue(3'd3, 4'd1, 16'h8001);
    wait_done("rol1", 16'h0003, 1'b1, 2, 1'b1, 1'b0);

    issue(3'd0, 4'd0, 16'h1234);
    wait_done("amt0", 16'h1234, 1'b0, 1, 1'b0, 1'b0);

    issue(3'd3, 4'd1, 16'h8001);
    wait_done("rol1b", 16'h0003, 1'b1, 2, 1'b1, 1'b0);
    issue(3'd6, 4'd5, 16'h1234);
    wait_done("rsv6", 16'h1234, 1'b0, 1, 1'b0, 1'b0);

    // Start held through SHIFT and DONE must be ignored; the next command
    // is issued in the first IDLE cycle after Done.
    issue(3'd0, 4'd3, 16'h0001);
    wait_done("busy_start", 16'h0008, 1'b0, 4, 1'b1, 1'b1);
    issue(3'd4, 4'd1, 16'h0001);
    wait_done("b2b", 16'h8000, 1'b1, 2, 1'b1, 1'b0);

    issue(3'd0, 4'd10, 16'h00FF);
    repeat (3) @(negedge CLK);
    check("pre_rst busy", Busy, 1'b1);
    nRST = 1'b0;
    #1;
    check("mid_rst busy", Busy, 1'b0);
    check("mid_rst done", Done, 1'b0);
    check("mid_rst result", Result, 16'h0);
    check("mid_rst carry", Carry, 1'b0);
    check("mid_rst shb", ShB, 16'h0);
    check("mid_rst shselect", ShSelect, 2'b00);
    check("mid_rst fills", {ShInL, ShInR}, 2'b00);
    @(negedge CLK);
    nRST = 1'b1;
    begin
      int done_cnt = 0;
      for (int k = 0; k < 15; k++) begin
        @(negedge CLK);
        if (Done) done_cnt++;
      end
      check("post_rst no_done", done_cnt, 0);
      check("post_rst result", Result, 16'h0);
    end

    issue(3'd1, 4'd4, 16'h00F0);
    wait_done("after_rst", 16'h000F, 1'b0, 5, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer16.md
# shift_sequencer16

Multi-cycle shift/rotate controller for the 16-bit single-step shifter. It accepts a shift command (operation, operand, amount 0–15) through a start/busy/done handshake. It then drives the shifter's Select/B/InL/InR inputs for one single-bit step per clock, feeding HOut back into an internal working register. It sits between the ALU control path and the external shifter instance; the shifter itself stays purely combinational.

## Interface
Parameters:
- WIDTH, 16, datapath width; fixed at 16 for this block, since the shifter is 16-bit.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- nRST  in  1  asynchronous active-low reset.
- Start  in  1  command strobe; sampled only in IDLE.
- Op  in  3  operation: 0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5–7 reserved.
- Amount  in  4  shift count 0–15.
- Operand  in  16  value to shift.
- Busy  out  1  high whenever state ≠ IDLE.
- Done  out  1  single-cycle pulse when Result/Carry become valid.
- Result  out  16  shifted value; holds until the next accepted Start or reset.
- Carry  out  1  last bit shifted or rotated out; 0 when Amount=0.
- ShSelect  out  2  to shifter Select. Encoding: 00 pass B, 01 shift left one (bit0 ← InR), 10 shift right one (bit15 ← InL), 11 unused, never driven.
- ShB  out  16  to shifter B; equals the working register R.
- ShInL  out  1  MSB fill for right shifts.
- ShInR  out  1  LSB fill for left shifts.
- ShHOut  in  16  from shifter HOut.

## Operation
- Registers: R[15:0], Cnt[3:0], OpReg[2:0], state, Carry, Result.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ShSelect=00.
  - On Start=1: R←Operand, Cnt←Amount, OpReg←Op, Carry←0.
  - Next state is SHIFT if Amount≠0 and Op≤4; otherwise DONE.
- SHIFT, every cycle:
  - R←ShHOut.
  - Carry←the bit leaving R: R[15] for LSL/ROL, R[0] for LSR/ASR/ROR.
  - Cnt←Cnt−1.
  - When Cnt=1 this cycle, the next state is DONE.
- Shifter drive in SHIFT:
  - LSL: ShSelect=01, ShInR=0.
  - LSR: ShSelect=10, ShInL=0.
  - ASR: ShSelect=10, ShInL=R[15].
  - ROL: ShSelect=01, ShInR=R[15].
  - ROR: ShSelect=10, ShInL=R[0].
  - Unused fill input is 0.
- DONE, one cycle only:
  - Done=1, Result←R (registered on entry, so Result is valid in the same cycle as Done).
  - ShSelect=00.
  - Next state IDLE.
- Reserved Op (5–7): treated as pass-through. Go to DONE, Result=Operand, Carry=0.
- Start while Busy=1, including the DONE cycle, is ignored. No queuing.
- Start during the first IDLE cycle after DONE is accepted. Back-to-back throughput is Amount+2 cycles per command.
- Operand/Op/Amount are sampled only at acceptance. Later changes have no effect.
- nRST low at any time, including mid-SHIFT:
  - Immediately: state IDLE, R=0, Cnt=0, OpReg=0, Result=0, Carry=0, Done=0, Busy=0.
  - Shifter drive outputs go to 0 (ShSelect=00, ShB=0, ShInL=ShInR=0).
  - The in-flight command is discarded.

## Timing
- Start accepted at edge t. With N=Amount:
  - N>0: SHIFT during cycles t+1..t+N; Done high in cycle t+N+1; Busy high t+1..t+N+1.
  - N=0 or reserved Op: Done high in cycle t+1; Busy high t+1 only.
- The ShHOut path is combinational through the external shifter. The R→ShB→HOut→R loop must close in one clock.
- Done is exactly one cycle wide. Result and Carry are stable from the Done cycle until the next acceptance edge.

## Test plan
- Reset values: assert nRST=0 asynchronously mid-cycle → all outputs 0 immediately. Release, then Start LSL Operand=0x8001 Amount=1 at t → Done at t+2, Result=0x0002, Carry=1.
- ASR 0x8000 by 15 → Result=0xFFFF, Carry=0, Done at t+16, Busy high for exactly 16 cycles. LSR 0xFFFF by 8 → 0x00FF, Carry=1.
- ROR 0x000F by 4 → Result=0xF000, Carry=1. ROL 0x8001 by 1 → 0x0003, Carry=1.
- Amount=0 with Operand=0x1234, and reserved Op=6 with Amount=5 → Done at t+1, Result=0x1234, Carry=0. ShSelect never leaves 00.
- Start pulsed every cycle while Busy, with new Operand values → only the first command executes. A Start in the cycle after Done is accepted and produces a correct second result.
- nRST pulsed during SHIFT of LSL 0x00FF by 10 → no Done pulse for that command, Result=0. A subsequent command completes normally.
